sreg_rx: RTL and testbench

SREG_RX -- requirements
Module: sreg_rx

---
 rtl/sreg_rx.sv | 191 +++++++++++++++++++
 tb/tb_sreg_rx.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sreg_rx.sv
// sreg_rx -- serial shift-register receiver.
//
// Collects WIDTH-bit frames, LSB first, from an externally clocked serial
// link (sclk/shift/sdata) into the clk domain. It hands each complete word to
// a consumer through a valid/ack pair.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous reset, ACTIVE-HIGH (reset while 1)
//   sclk        serial bit clock, data valid on its rising edge
//   shift       frame enable, high for the whole frame
//   sdata       serial data, LSB first
//   data_ack    consumer accepts data_out
//   data_out    last complete received word
//   data_valid  data_out holds an unacknowledged word
//   busy        FSM is not in IDLE
//   overrun     sticky, an unacknowledged word was overwritten
//   frame_err   one-cycle pulse when a partial frame is discarded
//
// Build option
//   SREG_RX_TIMEOUT_EN  when defined, a frame whose sclk stays idle for
//                       TIMEOUT_CYCLES clk cycles is aborted. When it is not
//                       defined, RECV waits indefinitely.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | no frame, bit counter and shift register held at zero
// RECV     | shifting in bits on each synchronized sclk rising edge
// DONE     | one cycle, publish shift register to data_out
// WAIT_END | frame finished or timed out, wait for shift to drop

module sreg_rx #(
   parameter int WIDTH          = 42,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sclk,
   input  logic             shift,
   input  logic             sdata,
   input  logic             data_ack,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   output logic             busy,
   output logic             overrun,
   output logic             frame_err
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RECV     = 2'd1,
      DONE     = 2'd2,
      WAIT_END = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [1:0]         sclk_sync_q, shift_sync_q, sdata_sync_q;
   logic               sclk_dly_q;
   logic [WIDTH-1:0]   sreg_q;
   logic [CNT_W-1:0]   bit_cnt_q;
   logic [WIDTH-1:0]   data_out_q;
   logic               data_valid_q, busy_q, overrun_q, frame_err_q;

   logic               sclk_s, shift_s, sdata_s;
   logic               bit_evt, last_bit, abort, tmo_hit;

   assign sclk_s   = sclk_sync_q[1];
   assign shift_s  = shift_sync_q[1];
   assign sdata_s  = sdata_sync_q[1];
   assign bit_evt  = sclk_s & ~sclk_dly_q;
   assign last_bit = (bit_cnt_q == CNT_W'(WIDTH - 1));

`ifdef SREG_RX_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TMO_W-1:0] tmo_q;

   // Fires on the cycle the idle count would reach TIMEOUT_CYCLES.
   assign tmo_hit = (state_q == RECV) && !bit_evt &&
                    (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

   // Held at zero outside RECV, so every RECV entry starts from zero.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         tmo_q <= '0;
      end else if (state_q != RECV || bit_evt || tmo_hit) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_q + 1'b1;
      end
   end
`else
   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      abort   = 1'b0;
      case (state_q)
         IDLE: begin
            if (shift_s) state_d = RECV;
         end
         RECV: begin
            // A completing bit event wins over a simultaneous drop of shift.
            if (bit_evt && last_bit) begin
               state_d = DONE;
            end else if (!shift_s) begin
               state_d = IDLE;
               abort   = 1'b1;
            end else if (tmo_hit) begin
               state_d = WAIT_END;
               abort   = 1'b1;
            end
         end
         DONE: begin
            state_d = WAIT_END;
         end
         WAIT_END: begin
            if (!shift_s) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q      <= IDLE;
         sclk_sync_q  <= '0;
         shift_sync_q <= '0;
         sdata_sync_q <= '0;
         sclk_dly_q   <= 1'b0;
         sreg_q       <= '0;
         bit_cnt_q    <= '0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         overrun_q    <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         sclk_sync_q  <= {sclk_sync_q[0],  sclk};
         shift_sync_q <= {shift_sync_q[0], shift};
         sdata_sync_q <= {sdata_sync_q[0], sdata};
         sclk_dly_q   <= sclk_s;

         state_q      <= state_d;
         busy_q       <= (state_d != IDLE);
         frame_err_q  <= abort;

         case (state_q)
            RECV: begin
               if (abort) begin
                  sreg_q    <= '0;
                  bit_cnt_q <= '0;
               end else if (bit_evt) begin
                  sreg_q    <= {sdata_s, sreg_q[WIDTH-1:1]};
                  bit_cnt_q <= last_bit ? '0 : bit_cnt_q + 1'b1;
               end
            end
            IDLE: begin
               sreg_q    <= '0;
               bit_cnt_q <= '0;
            end
            default: begin
               bit_cnt_q <= '0;
            end
         endcase

         // An ack coinciding with DONE consumes the old word, so the new
         // word does not count as an overrun.
         if (state_q == DONE) begin
            data_out_q   <= sreg_q;
            data_valid_q <= 1'b1;
            overrun_q    <= data_valid_q & ~data_ack;
         end else if (data_ack && data_valid_q) begin
            data_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
         end
      end
   end

   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;
   assign busy       = busy_q;
   assign overrun    = overrun_q;
   assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_sreg_rx.sv
// Testbench for sreg_rx: directed frames plus randomized frames, all checked
// against a transaction-level model of the consumer-visible outputs.

module tb_sreg_rx;

   localparam int W = 42;

   logic         clk = 1'b0;
   logic         rst_n, sclk, shift, sdata, data_ack;
   logic [W-1:0] data_out;
   logic         data_valid, busy, overrun, frame_err;

   int n_tests = 0;
   int n_fail  = 0;

   logic [W-1:0] exp_data;
   logic         exp_valid, exp_ovr;

   sreg_rx dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sclk       (sclk),
      .shift      (shift),
      .sdata      (sdata),
      .data_ack   (data_ack),
      .data_out   (data_out),
      .data_valid (data_valid),
      .busy       (busy),
      .overrun    (overrun),
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drives nbits of w LSB first with shift high; shift is left high.
   task automatic send_bits(input logic [W-1:0] w, input int nbits,
                            input bit chk_lat, input bit ack_done);
      shift = 1'b1;
      tick(4);
      for (int i = 0; i < nbits; i++) begin
         sclk  = 1'b0;
         sdata = w[i];
         tick($urandom_range(2, 4));
         sclk = 1'b1;
         if (i == nbits - 1 && (chk_lat || ack_done)) begin
            // Edge 1 samples sclk high; data_valid expected after edge 4.
            repeat (3) @(posedge clk);
            #1;
            if (chk_lat) chk("lat_before", 64'(data_valid), 64'd0);
            @(negedge clk);
            if (ack_done) data_ack = 1'b1;
            @(posedge clk);
            #1;
            if (chk_lat) chk("lat_at", 64'(data_valid), 64'd1);
            @(negedge clk);
            data_ack = 1'b0;
            tick(1);
         end else begin
            tick($urandom_range(2, 4));
         end
      end
      sclk = 1'b0;
      tick(2);
   endtask

   task automatic end_frame(input int exp_pulses, input string tag);
      int cnt;
      cnt   = 0;
      shift = 1'b0;
      repeat (8) begin
         @(posedge clk);
         #1;
         if (frame_err) cnt++;
      end
      @(negedge clk);
      chk(tag, 64'(cnt), 64'(exp_pulses));
   endtask

   task automatic model_frame(input logic [W-1:0] w, input bit ack_done);
      exp_ovr   = exp_valid && !ack_done;
      exp_valid = 1'b1;
      exp_data  = w;
   endtask

   task automatic full_frame(input logic [W-1:0] w, input bit chk_lat, input bit ack_done);
      send_bits(w, W, chk_lat, ack_done);
      end_frame(0, "no_ferr");
      model_frame(w, ack_done);
   endtask

   task automatic do_ack;
      data_ack = 1'b1;
      tick(1);
      data_ack = 1'b0;
      tick(1);
      if (exp_valid) begin
         exp_valid = 1'b0;
         exp_ovr   = 1'b0;
      end
   endtask

   task automatic chk_outputs(input string tag);
      chk({tag, "_data"},  64'(data_out),   64'(exp_data));
      chk({tag, "_valid"}, 64'(data_valid), 64'(exp_valid));
      chk({tag, "_ovr"},   64'(overrun),    64'(exp_ovr));
      chk({tag, "_busy"},  64'(busy),       64'd0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [63:0]  r;
      logic [W-1:0] w;
      int           cnt;
      bit           seen;

      rst_n    = 1'b1;
      sclk     = 1'b0;
      shift    = 1'b0;
      sdata    = 1'b0;
      data_ack = 1'b0;
      exp_data  = '0;
      exp_valid = 1'b0;
      exp_ovr   = 1'b0;
      tick(3);
      chk("rst_data",  64'(data_out),   64'd0);
      chk("rst_valid", 64'(data_valid), 64'd0);
      chk("rst_busy",  64'(busy),       64'd0);
      chk("rst_ferr",  64'(frame_err),  64'd0);
      rst_n = 1'b0;
      tick(3);

      // Alternating pattern, with output latency check.
      full_frame(42'h2AA_AAAA_AAAA, 1'b1, 1'b0);
      chk_outputs("alt");
      tick(20);
      chk("alt_hold_valid", 64'(data_valid), 64'd1);
      do_ack();
      chk("alt_ack_valid", 64'(data_valid), 64'd0);

      // Partial frame, shift dropped after 10 bits.
      send_bits(42'h3FF_FFFF_FFFF, 10, 1'b0, 1'b0);
      chk("partial_busy", 64'(busy), 64'd1);
      end_frame(1, "partial_ferr");
      chk_outputs("partial");

      // Overrun then a single ack clears it.
      full_frame(42'h1, 1'b0, 1'b0);
      full_frame(42'h3FF_FFFF_FFFF, 1'b0, 1'b0);
      chk_outputs("ovr");
      do_ack();
      chk_outputs("ovr_ack");

      // Ack in the DONE cycle of a second frame.
      full_frame(42'h123_4567_89AB, 1'b0, 1'b0);
      full_frame(42'h0ED_CBA9_8765, 1'b0, 1'b1);
      chk_outputs("ackdone");
      do_ack();

      // Reset in mid-frame with an unacknowledged word pending.
      full_frame(42'h0F0_F0F0_F0F0, 1'b0, 1'b0);
      send_bits(42'h3C3_C3C3_C3C3, 20, 1'b0, 1'b0);
      chk("pre_rst_busy", 64'(busy), 64'd1);
      #2 rst_n = 1'b1;
      #1;
      chk("arst_data",  64'(data_out),   64'd0);
      chk("arst_valid", 64'(data_valid), 64'd0);
      chk("arst_busy",  64'(busy),       64'd0);
      chk("arst_ovr",   64'(overrun),    64'd0);
      chk("arst_ferr",  64'(frame_err),  64'd0);
      exp_data  = '0;
      exp_valid = 1'b0;
      exp_ovr   = 1'b0;
      shift     = 1'b0;
      cnt = 0;
      repeat (3) begin
         @(negedge clk);
         if (frame_err) cnt++;
      end
      rst_n = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (frame_err) cnt++;
      end
      chk("arst_no_ferr", 64'(cnt), 64'd0);
      full_frame(42'h155_5555_5555, 1'b1, 1'b0);
      chk_outputs("post_rst");
      do_ack();

      // Idle sclk with shift held high.
      send_bits(42'h1F, 5, 1'b0, 1'b0);
`ifdef SREG_RX_TIMEOUT_EN
      cnt  = 0;
      seen = 1'b0;
      while (!seen && cnt < 400) begin
         @(posedge clk);
         #1;
         cnt++;
         if (frame_err) seen = 1'b1;
      end
      chk("tmo_seen", 64'(seen), 64'd1);
      chk("tmo_window", 64'(cnt >= 245 && cnt <= 260), 64'd1);
      chk("tmo_busy", 64'(busy), 64'd1);
      end_frame(0, "tmo_end_ferr");
`else
      cnt  = 0;
      seen = 1'b0;
      repeat (1000) begin
         @(posedge clk);
         #1;
         if (!busy) cnt++;
         if (frame_err) seen = 1'b1;
      end
      chk("notmo_busy_low", 64'(cnt), 64'd0);
      chk("notmo_ferr", 64'(seen), 64'd0);
      @(negedge clk);
      end_frame(1, "notmo_end_ferr");
`endif
      chk_outputs("idle_sclk");

      // Randomized frames with random ack placement.
      for (int k = 0; k < 12; k++) begin
         r = {$urandom, $urandom};
         w = r[W-1:0];
         full_frame(w, 1'b0, ($urandom_range(0, 3) == 0));
         chk_outputs("rnd");
         if ($urandom_range(0, 1) == 1) begin
            do_ack();
            chk("rnd_ack_valid", 64'(data_valid), 64'd0);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
